// File: rtl/door_plant_model.sv
// Motorised door plant: turns open/close motor commands into limit switches, position and fault flags.
// Optional feature macro: DOOR_OBSTRUCTION_EN (obstruct input halts closing and raises obs_flag).
module door_plant_model #(
  parameter int TRAVEL   = 16,
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       ma,
  input  logic       mc,
  input  logic       obstruct,
  output logic       la,
  output logic       lc,
  output logic [7:0] pos,
  output logic       moving,
  output logic       fault,
  output logic       obs_flag
);

  typedef enum logic [1:0] {S_IDLE, S_OPENING, S_CLOSING, S_FAULT} state_t;

  localparam logic [7:0] TMAX = 8'(TRAVEL);
  localparam logic [7:0] PMAX = 8'(PRESCALE - 1);

  state_t     r_state;
  logic [7:0] r_pos;
  logic [7:0] r_pre;
  logic       r_la, r_lc, r_moving, r_fault, r_obs;

  state_t     w_nxt;
  logic       w_obs;
  logic       w_sat;
  logic [7:0] w_base;
  logic [7:0] w_pre;
  logic [7:0] w_pos;

  always_comb begin
    w_nxt = S_IDLE;
    if (ma && mc)
      w_nxt = S_FAULT;
    else if (r_state == S_FAULT)
      w_nxt = (ma || mc) ? S_FAULT : S_IDLE;
    else if (ma)
      w_nxt = S_OPENING;
    else if (mc)
      w_nxt = S_CLOSING;

`ifdef DOOR_OBSTRUCTION_EN
    w_obs = (w_nxt == S_CLOSING) && obstruct;
`else
    w_obs = obstruct & 1'b0;
`endif

    // Entering a state (including a direction change) restarts the step count.
    w_base = (w_nxt != r_state) ? 8'd0 : r_pre;
    w_sat  = ((w_nxt == S_OPENING) && (r_pos == TMAX)) ||
             ((w_nxt == S_CLOSING) && (r_pos == 8'd0));
    w_pre  = 8'd0;
    w_pos  = r_pos;

    // The entry cycle counts as the first prescaler cycle, so a step lands every PRESCALE cycles.
    if ((w_nxt == S_OPENING) || (w_nxt == S_CLOSING)) begin
      if (w_sat) begin
        w_pre = 8'd0;
      end else if (w_obs) begin
        w_pre = w_base;
      end else if (w_base == PMAX) begin
        w_pre = 8'd0;
        w_pos = (w_nxt == S_OPENING) ? r_pos + 8'd1 : r_pos - 8'd1;
      end else begin
        w_pre = w_base + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pos    <= 8'd0;
      r_pre    <= 8'd0;
      r_la     <= 1'b0;
      r_lc     <= 1'b1;
      r_moving <= 1'b0;
      r_fault  <= 1'b0;
      r_obs    <= 1'b0;
    end else if (ena) begin
      r_state  <= w_nxt;
      r_pos    <= w_pos;
      r_pre    <= w_pre;
      r_la     <= (w_pos == TMAX);
      r_lc     <= (w_pos == 8'd0);
      r_moving <= (w_nxt == S_OPENING) || (w_nxt == S_CLOSING);
      r_fault  <= (w_nxt == S_FAULT);
      r_obs    <= w_obs;
    end
  end

  assign la       = r_la;
  assign lc       = r_lc;
  assign pos      = r_pos;
  assign moving   = r_moving;
  assign fault    = r_fault;
  assign obs_flag = r_obs;

endmodule

// File: tb/tb_door_plant_model.sv
// Bench for door_plant_model: vector table, hand-written corner sequences and randomized model check.
module tb_door_plant_model;

  localparam int TRAVEL   = 16;
  localparam int PRESCALE = 4;
`ifdef DOOR_OBSTRUCTION_EN
  localparam bit OBS_EN = 1'b1;
`else
  localparam bit OBS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0, ma = 1'b0, mc = 1'b0, obstruct = 1'b0;
  logic       la, lc, moving, fault, obs_flag;
  logic [7:0] pos;

  int total = 0;
  int bad = 0;

  door_plant_model #(.TRAVEL(TRAVEL), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ma(ma), .mc(mc), .obstruct(obstruct),
    .la(la), .lc(lc), .pos(pos), .moving(moving), .fault(fault), .obs_flag(obs_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 opening, 2 closing, 3 fault; run counts enabled motion cycles.
  int m_mode, m_pos, m_run, m_nm;
  bit m_obs;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_pos = 0; m_run = 0; m_obs = 0;
    end else if (ena) begin
      if (ma && mc)        m_nm = 3;
      else if (m_mode == 3) m_nm = (ma || mc) ? 3 : 0;
      else if (ma)         m_nm = 1;
      else if (mc)         m_nm = 2;
      else                 m_nm = 0;
      if (m_nm != m_mode) m_run = 0;
      m_mode = m_nm;
      m_obs = OBS_EN && (m_nm == 2) && obstruct;
      if (m_nm == 1 || m_nm == 2) begin
        if ((m_nm == 1 && m_pos == TRAVEL) || (m_nm == 2 && m_pos == 0)) m_run = 0;
        else if (!m_obs) begin
          m_run++;
          if (m_run == PRESCALE) begin
            m_run = 0;
            m_pos += (m_nm == 1) ? 1 : -1;
          end
        end
      end else m_run = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model", {19'd0, pos, la, lc, moving, fault, obs_flag},
          {19'd0, 8'(m_pos), m_pos == TRAVEL, m_pos == 0, m_mode == 1 || m_mode == 2,
           m_mode == 3, m_obs});
      chk("limits_excl", {31'd0, la & lc}, 32'd0);
    end
  end

  typedef struct {
    logic e, a, c;
    int n;
    logic [7:0] p;
    logic xla, xlc, xmv, xf;
    string nm;
  } vec_t;
  vec_t tv[$];

  function automatic void add(input logic e, a, c, input int n, input logic [7:0] p,
                              input logic xla, xlc, xmv, xf, input string nm);
    vec_t v;
    v.e = e; v.a = a; v.c = c; v.n = n; v.p = p;
    v.xla = xla; v.xlc = xlc; v.xmv = xmv; v.xf = xf; v.nm = nm;
    tv.push_back(v);
  endfunction

  task automatic do_reset();
    ena = 1'b1; ma = 1'b0; mc = 1'b0; obstruct = 1'b0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  int k, lc_at, cmd;

  initial begin
    add(1,1,0,  3,  0, 0,1,1,0, "open_pre_step");
    add(1,1,0,  1,  1, 0,0,1,0, "lc_fall_c4");
    add(1,1,0, 28,  8, 0,0,1,0, "pos8_c32");
    add(1,1,0, 31, 15, 0,0,1,0, "pos15_c63");
    add(1,1,0,  1, 16, 1,0,1,0, "la_rise_c64");
    add(1,1,0, 16, 16, 1,0,1,0, "open_sat_c80");
    add(1,0,1,  3, 16, 1,0,1,0, "close_pre_step");
    add(1,0,1,  1, 15, 0,0,1,0, "la_fall_c4");
    add(1,0,1, 59,  1, 0,0,1,0, "pos1_c63");
    add(1,0,1,  1,  0, 0,1,1,0, "lc_rise_c64");
    add(1,0,0,  1,  0, 0,1,0,0, "idle");
    add(1,1,0, 20,  5, 0,0,1,0, "open_to5");
    add(1,1,1,  1,  5, 0,0,0,1, "fault_enter");
    add(1,1,1,  2,  5, 0,0,0,1, "fault_overlap");
    add(1,1,0,  2,  5, 0,0,0,1, "fault_hold_ma");
    add(1,0,0,  1,  5, 0,0,0,0, "fault_exit");
    add(1,1,0,  3,  5, 0,0,1,0, "resume_pre");
    add(1,1,0,  1,  6, 0,0,1,0, "resume_pos6");
    add(1,1,0, 16, 10, 0,0,1,0, "open_to10");
    add(1,1,0,  2, 10, 0,0,1,0, "pre_at2");
    add(1,0,1,  3, 10, 0,0,1,0, "reverse_pre");
    add(1,0,1,  1,  9, 0,0,1,0, "reverse_pos9");
    add(1,0,0,  1,  9, 0,0,0,0, "idle9");
    add(1,1,0, 14, 12, 0,0,1,0, "open_to12_pre2");
    add(0,1,0, 10, 12, 0,0,1,0, "ena_low_hold");
    add(0,0,1,  3, 12, 0,0,1,0, "ena_low_ignores_cmd");
    add(1,1,0,  1, 12, 0,0,1,0, "pre_held_a");
    add(1,1,0,  1, 13, 0,0,1,0, "pre_held_step");

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_vals", {24'd0, pos, la, lc, moving, fault, obs_flag},
        {24'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    ena = 1'b1;
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("after_release", {24'd0, pos, la, lc, moving, fault}, {24'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0});

    foreach (tv[i]) begin
      ena = tv[i].e; ma = tv[i].a; mc = tv[i].c;
      repeat (tv[i].n) @(posedge clk);
      @(negedge clk);
      chk(tv[i].nm, {20'd0, pos, la, lc, moving, fault},
          {20'd0, tv[i].p, tv[i].xla, tv[i].xlc, tv[i].xmv, tv[i].xf});
    end

    // Asynchronous reset mid-motion.
    do_reset();
    ma = 1'b1;
    repeat (28) @(negedge clk);
    chk("pos7_before_rst", {24'd0, pos}, 32'd7);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {27'd0, pos == 8'd0, lc, la, moving, fault}, {27'd0, 5'b11000});
    ma = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Closing from pos 8 with obstruct held for the first 20 cycles.
    do_reset();
    ma = 1'b1;
    repeat (32) @(negedge clk);
    chk("pos8_before_close", {24'd0, pos}, 32'd8);
    ma = 1'b0; mc = 1'b1; obstruct = 1'b1;
    lc_at = 0;
    for (k = 1; k <= 200 && lc_at == 0; k++) begin
      @(negedge clk);
      if (k == 10) begin
        chk("obs_flag_mid", {31'd0, obs_flag}, {31'd0, OBS_EN});
        chk("obs_pos_mid", {24'd0, pos}, OBS_EN ? 32'd8 : 32'd6);
      end
      if (k == 20) obstruct = 1'b0;
      if (lc) lc_at = k;
    end
    chk("obs_close_cycles", lc_at, OBS_EN ? 32'd52 : 32'd32);
    mc = 1'b0;

    // Randomized commands with sticky choices, occasional ena drops and resets.
    do_reset();
    cmd = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 11) == 0) cmd = $urandom_range(0, 9);
      ma = (cmd >= 1 && cmd <= 4) || cmd == 9;
      mc = (cmd >= 5 && cmd <= 8) || cmd == 9;
      ena = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) obstruct = ~obstruct;
      if ($urandom_range(0, 799) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/door_plant_model.md
# door_plant_model

Cycle-accurate model of a motorised door that sits on the other side of the door-controller FSM. It takes the controller's motor commands (open/close) and produces the limit-switch signals (open limit, closed limit) from an internal position counter. It also produces a fault flag. It serves as on-chip stimulus for the controller and as a standalone demo on the Tiny Tapeout harness pins.

## Interface
- `TRAVEL`, default 16: door positions; 0 = fully closed, `TRAVEL` = fully open; legal range 2..255.
- `PRESCALE`, default 4: enabled cycles per position step; legal range 1..255.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low; clock clk.
- `ena` in 1: clock enable; when low, all state and outputs hold.
- `ma` in 1: motor-open command from the controller.
- `mc` in 1: motor-close command from the controller.
- `obstruct` in 1: obstacle in doorway (used only with `DOOR_OBSTRUCTION_EN`).
- `la` out 1: open limit switch, high iff `pos == TRAVEL`.
- `lc` out 1: closed limit switch, high iff `pos == 0`.
- `pos` out 8: current position, zero-extended.
- `moving` out 1: high in OPENING or CLOSING.
- `fault` out 1: high in FAULT.
- `obs_flag` out 1: obstruction halt active.

## Operation
- State register with four states: IDLE, OPENING, CLOSING, FAULT.
- Reset values:
  - State IDLE, `pos` 0, prescaler 0.
  - `lc` 1, `la` 0, `moving` 0, `fault` 0, `obs_flag` 0.
- Command decode, sampled each enabled cycle:
  - `ma & mc` → FAULT from any state.
  - `ma` only → OPENING.
  - `mc` only → CLOSING.
  - Neither → IDLE.
- FAULT:
  - `pos` frozen.
  - Exits to IDLE on the first enabled cycle that samples `ma = mc = 0`.
  - Any other command keeps the block in FAULT.
- Prescaler:
  - Increments each enabled cycle in OPENING or CLOSING.
  - On reaching `PRESCALE-1` it wraps to 0 and `pos` steps ±1.
  - Cleared to 0 on entry to any state and on any direction change.
- Saturation:
  - OPENING at `pos == TRAVEL`: `pos` holds, prescaler holds at 0, `moving` stays 1.
  - CLOSING at `pos == 0`: same behaviour.
- Direction reversal (OPENING↔CLOSING) is legal with no fault; the prescaler restarts from 0.
- `la`, `lc` and `pos` are registered and update in the same edge. There is never a cycle where `la` and `lc` are both 1.
- `pos` arithmetic is 8-bit unsigned. It can never leave 0..`TRAVEL`.

## Timing
- A command sampled at edge N changes state at edge N; `moving`/`fault` are valid after edge N.
- First position step occurs `PRESCALE` enabled cycles after entry to OPENING/CLOSING.
- Full travel 0→`TRAVEL` takes `TRAVEL*PRESCALE` enabled cycles. Default: 64.
- `lc` falls on the edge `pos` becomes 1. `la` rises on the edge `pos` becomes `TRAVEL`.
- `ena` low freezes the prescaler, state, `pos` and all outputs; no cycles are counted.
- Asynchronous reset mid-motion returns the block to reset values immediately. Release is synchronous to the next edge.

## Configuration
- `DOOR_OBSTRUCTION_EN` defined:
  - In CLOSING with `obstruct` = 1, `pos` and the prescaler freeze and `obs_flag` = 1 (registered, one-cycle latency).
  - When `obstruct` falls, `obs_flag` clears next edge and closing resumes from the held prescaler value.
  - OPENING is unaffected by `obstruct`.
- `DOOR_OBSTRUCTION_EN` undefined: `obstruct` is ignored and `obs_flag` is tied 0.

## Test plan
- Reset, then hold `ma` = 1 with defaults:
  - `lc` falls at cycle 4.
  - `pos` = 8 at cycle 32.
  - `la` rises at cycle 64.
  - `pos` stays 16 for cycles 65–80, `moving` = 1.
- From `pos` = 16, hold `mc` = 1:
  - `la` falls at cycle 4.
  - `lc` rises at cycle 64.
  - `la` and `lc` are never both 1.
- At `pos` = 5, assert `ma = mc = 1` for 3 cycles, then `ma` only:
  - `fault` = 1 and `pos` = 5 throughout the overlap.
  - `ma` alone keeps FAULT.
  - Drop both for 1 cycle → IDLE, `fault` = 0.
  - Then `ma` → `pos` = 6 after 4 cycles.
- At `pos` = 10 opening, with prescaler at 2, switch to `mc`: `pos` = 9 exactly 4 cycles later.
- Toggle `ena` low for 10 cycles mid-opening: `pos` and the prescaler hold; total travel = 64 enabled cycles. Pulse `rst_n` low at `pos` = 7: `pos` = 0, `lc` = 1 immediately.
- With `DOOR_OBSTRUCTION_EN`, closing from `pos` = 8, `obstruct` high for 20 cycles:
  - `obs_flag` = 1 and `pos` = 8 throughout.
  - After release, `lc` rises 32 enabled cycles later.
  - Without the macro, the same stimulus closes in 32 cycles and `obs_flag` stays 0.
